uart_tx_param: RTL and testbench



---
 rtl/uart_tx_param_if.sv | 19 +
 rtl/uart_tx_param.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_param.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: byte handshake between a producer and the UART transmitter.
// The master drives tx_data/tx_valid. The slave (transmitter) drives tx_ready.
interface uart_tx_param_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// Frame format: start bit, DATA_BITS data bits LSB first, optional parity bit,
// then STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT clocks.
// Define UART_TX_PARITY_EN to insert the parity bit. PARITY_ODD then selects
// odd parity (1) or even parity (0).
// All outputs are registered. Reset is asynchronous and active-high.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 256,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_param_if.slave        bus,
    output logic                  tx_busy,
    output logic                  txd
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
        DATA_BITS < 5 || DATA_BITS > 8 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
        $error("uart_tx_param: illegal parameter value");
    end

    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 ready_q;
    logic                 bit_end;

    assign bit_end      = (cnt == CNT_MAX);
    assign bus.tx_ready = ready_q;

`ifdef UART_TX_PARITY_EN
    logic par_q;

    // The parity of the accepted byte is captured when the byte is latched.
    // The shift register no longer holds the whole byte by the time the parity bit is sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (state == S_IDLE && bus.tx_valid && ready_q) begin
            par_q <= (^bus.tx_data[DATA_BITS-1:0]) ^ (PARITY_ODD != 0);
        end
    end
`endif

    // Frame sequencer. Each branch loads txd with the level of the state it enters.
    // This keeps txd registered and aligned with the state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            txd     <= 1'b1;
            ready_q <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.tx_valid && ready_q) begin
                        state   <= S_START;
                        shreg   <= bus.tx_data[DATA_BITS-1:0];
                        cnt     <= '0;
                        bit_idx <= '0;
                        txd     <= 1'b0;
                        ready_q <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        cnt     <= '0;
                        bit_idx <= '0;
                        txd     <= shreg[0];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        shreg <= shreg >> 1;
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= S_PARITY;
                            txd     <= par_q;
`else
                            state   <= S_STOP;
                            txd     <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state   <= S_STOP;
                        cnt     <= '0;
                        bit_idx <= '0;
                        txd     <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif

                S_STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == LAST_STOP) begin
                            state   <= S_IDLE;
                            bit_idx <= '0;
                            ready_q <= 1'b1;
                            tx_busy <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                        txd <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    bit_idx <= '0;
                    txd     <= 1'b1;
                    ready_q <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: bench for uart_tx_param. It drives two instances with different
// frame formats and compares every frame cycle against a bit-list model.
// Define UART_TX_PARITY_EN for both the bench and the RTL to cover the parity bit.
module tb_uart_tx_param;

    localparam int CPB = 4;

`ifdef UART_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    logic       clk;
    logic       rst;
    logic       vld   [2];
    logic [7:0] dat   [2];
    logic       rdy_o [2];
    logic       busy_o[2];
    logic       txd_o [2];

    int checks = 0;
    int errors = 0;

    logic [7:0] pend[$];

    uart_tx_param_if ifa ();
    uart_tx_param_if ifb ();

    assign ifa.tx_valid = vld[0];
    assign ifa.tx_data  = dat[0];
    assign rdy_o[0]     = ifa.tx_ready;
    assign ifb.tx_valid = vld[1];
    assign ifb.tx_data  = dat[1];
    assign rdy_o[1]     = ifb.tx_ready;

    uart_tx_param #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .STOP_BITS    (1),
        .PARITY_ODD   (0)
    ) dut_a (
        .clk     (clk),
        .rst     (rst),
        .bus     (ifa),
        .tx_busy (busy_o[0]),
        .txd     (txd_o[0])
    );

    uart_tx_param #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (5),
        .STOP_BITS    (2),
        .PARITY_ODD   (1)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .bus     (ifb),
        .tx_busy (busy_o[1]),
        .txd     (txd_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int cfg_dbits(input int sel);
        return (sel == 0) ? 8 : 5;
    endfunction

    function automatic int cfg_sbits(input int sel);
        return (sel == 0) ? 1 : 2;
    endfunction

    function automatic int cfg_odd(input int sel);
        return (sel == 0) ? 0 : 1;
    endfunction

    function automatic int frame_bits(input int sel);
        return 1 + cfg_dbits(sel) + PAR_EN + cfg_sbits(sel);
    endfunction

    // Line level for bit slot pos of a frame carrying byte b.
    function automatic logic line_level(input int sel, input logic [7:0] b, input int pos);
        int dbits;
        int ones;
        dbits = cfg_dbits(sel);
        if (pos == 0) return 1'b0;
        if (pos <= dbits) return b[pos-1];
        if (PAR_EN != 0 && pos == dbits + 1) begin
            ones = 0;
            for (int i = 0; i < dbits; i++) ones += int'(b[i]);
            return logic'((ones % 2) ^ cfg_odd(sel));
        end
        return 1'b1;
    endfunction

    task automatic check_idle(input int sel, input string tag);
        check($sformatf("%s txd s%0d", tag, sel), 32'(txd_o[sel]), 32'd1);
        check($sformatf("%s ready s%0d", tag, sel), 32'(rdy_o[sel]), 32'd1);
        check($sformatf("%s busy s%0d", tag, sel), 32'(busy_o[sel]), 32'd0);
    endtask

    // Sends every byte in pend back to back with tx_valid held high.
    // Each frame is checked cycle by cycle, including the single idle cycle after it.
    task automatic xfer(input int sel);
        int w;
        int len;
        int n;
        n = pend.size();
        @(negedge clk);
        dat[sel] = pend[0];
        vld[sel] = 1'b1;
        w = 0;
        while (rdy_o[sel] !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("ready_wait s%0d", sel), 32'(rdy_o[sel]), 32'd1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i == n - 1) vld[sel] = 1'b0;
            dat[sel] = 8'($urandom);
            len = frame_bits(sel) * CPB;
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                check($sformatf("txd s%0d b%0h c%0d", sel, pend[i], c), 32'(txd_o[sel]),
                      32'(line_level(sel, pend[i], c / CPB)));
                check($sformatf("busy s%0d c%0d", sel, c), 32'(busy_o[sel]), 32'd1);
                check($sformatf("ready s%0d c%0d", sel, c), 32'(rdy_o[sel]), 32'd0);
            end
            @(negedge clk);
            check_idle(sel, "gap");
            if (i < n - 1) dat[sel] = pend[i+1];
        end
    endtask

    initial begin
        rst    = 1'b1;
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        dat[0] = '0;
        dat[1] = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) check_idle(s, "por");
        rst = 1'b0;

        // Mid-cycle reset while idle, then a long idle hold.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) check_idle(s, "rst_async");
        @(negedge clk);
        rst = 1'b0;
        repeat (100) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) check_idle(s, "hold");
        end

        pend = {8'h41};
        xfer(0);

        pend = {8'h55, 8'hAA};
        xfer(0);

        pend = {8'hFF};
        xfer(1);

        pend = {8'h03, 8'h07};
        xfer(0);
        xfer(1);

        repeat (6) begin
            int sel;
            int nb;
            sel = int'($urandom_range(0, 1));
            nb  = int'($urandom_range(1, 3));
            pend = {};
            for (int k = 0; k < nb; k++) pend.push_back(8'($urandom));
            xfer(sel);
        end

        // Reset in the middle of data bit 3 of 0x00, then a clean frame.
        @(negedge clk);
        dat[0] = 8'h00;
        vld[0] = 1'b1;
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        repeat (18) @(negedge clk);
        check("midframe txd", 32'(txd_o[0]), 32'd0);
        check("midframe busy", 32'(busy_o[0]), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_idle(0, "midframe_rst");
        @(negedge clk);
        rst = 1'b0;
        pend = {8'h41};
        xfer(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
